// File: rtl/mdu_pkg.sv
// Shared types and op-decode helpers for the multiply/divide unit.
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  // State names carry ST_ so they do not collide with the op encodings above.
  typedef enum logic [1:0] {
    MDU_ST_IDLE,
    MDU_ST_MUL,
    MDU_ST_DIV,
    MDU_ST_FIX
  } mdu_state_e;

  function automatic logic op_is_div(mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic op_is_signed(mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// One-bit-per-cycle datapath: shift-add multiply or restoring divide on unsigned magnitudes.
module mdu_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic                 div_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [2*WIDTH-1:0]   acc_o,
  output logic                 last_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q, acc_nxt;
  logic [WIDTH-1:0]   opnd_q;
  logic [CW-1:0]      cnt_q;
  logic               div_q;
  logic [WIDTH:0]     sum, rem_sh, diff;

  // acc = {upper, lower}: lower starts as multiplier / dividend, upper as zero.
  always_comb begin
    sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
    diff   = rem_sh - {1'b0, opnd_q};
    acc_nxt = acc_q;
    if (div_q) begin
      if (!diff[WIDTH]) acc_nxt = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else              acc_nxt = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      if (acc_q[0]) acc_nxt = {sum, acc_q[WIDTH-1:1]};
      else          acc_nxt = {1'b0, acc_q[2*WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
    end else if (load_i) begin
      acc_q  <= {{WIDTH{1'b0}}, a_i};
      opnd_q <= b_i;
      cnt_q  <= '0;
      div_q  <= div_i;
    end else if (step_i) begin
      acc_q <= acc_nxt;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign acc_o  = acc_q;
  assign last_o = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/mul_div_unit.sv
// MIPS HI/LO multiply/divide unit: FSM, sign handling, FIX cycle and HI/LO registers.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [1:0]       op_i2,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  input  logic             rd_hilo_i,
  input  logic             wr_hi_i,
  input  logic             wr_lo_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             stall_o
);

  mdu_state_e         state_q;
  mdu_op_e            op_q, op_in;
  logic               a_neg_q, b_neg_q, b_zero_q;
  logic [WIDTH-1:0]   a_q, hi_q, lo_q;
  logic               busy_q, done_q;
  logic               in_signed, core_load, core_step, core_last, sign_diff;
  logic [WIDTH-1:0]   a_mag, b_mag, quo, rem, fix_hi, fix_lo;
  logic [2*WIDTH-1:0] acc, prod;

  assign op_in     = mdu_op_e'(op_i2);
  assign in_signed = op_is_signed(op_in);
  assign a_mag     = (in_signed && a_i[WIDTH-1]) ? -a_i : a_i;
  assign b_mag     = (in_signed && b_i[WIDTH-1]) ? -b_i : b_i;

  // Handshake: start_i is a valid with no ready; it is taken only in IDLE without
  // flush_i. While busy, stall_o is the back-pressure that makes the instr re-present.
  assign core_load = (state_q == MDU_ST_IDLE) && start_i && !flush_i;
  assign core_step = ((state_q == MDU_ST_MUL) || (state_q == MDU_ST_DIV)) && !flush_i;

  mdu_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (core_load),
    .step_i  (core_step),
    .div_i   (op_is_div(op_in)),
    .a_i     (a_mag),
    .b_i     (b_mag),
    .acc_o   (acc),
    .last_o  (core_last)
  );

  // Sign fix-up; the neg flags are only ever set for signed ops.
  always_comb begin
    sign_diff = a_neg_q ^ b_neg_q;
    prod      = sign_diff ? -acc : acc;
    quo       = sign_diff ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem       = a_neg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    fix_hi    = prod[2*WIDTH-1:WIDTH];
    fix_lo    = prod[WIDTH-1:0];
    if (op_is_div(op_q)) begin
      if (b_zero_q) begin
        fix_hi = a_q;
        fix_lo = '1;
      end else begin
        fix_hi = rem;
        fix_lo = quo;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= MDU_ST_IDLE;
      op_q     <= MDU_MULT;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
      a_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        MDU_ST_IDLE: begin
          if (flush_i) begin
            state_q <= MDU_ST_IDLE;
          end else if (start_i) begin
            state_q  <= op_is_div(op_in) ? MDU_ST_DIV : MDU_ST_MUL;
            busy_q   <= 1'b1;
            op_q     <= op_in;
            a_q      <= a_i;
            a_neg_q  <= in_signed && a_i[WIDTH-1];
            b_neg_q  <= in_signed && b_i[WIDTH-1];
            b_zero_q <= (b_i == '0);
          end else begin
            if (wr_hi_i) hi_q <= wdata_i;
            if (wr_lo_i) lo_q <= wdata_i;
          end
        end
        MDU_ST_MUL, MDU_ST_DIV: begin
          if (flush_i) begin
            state_q <= MDU_ST_IDLE;
            busy_q  <= 1'b0;
          end else if (core_last) begin
            state_q <= MDU_ST_FIX;
          end
        end
        MDU_ST_FIX: begin
          state_q <= MDU_ST_IDLE;
          busy_q  <= 1'b0;
          if (!flush_i) begin
            hi_q   <= fix_hi;
            lo_q   <= fix_lo;
            done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= MDU_ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign stall_o = busy_q & (start_i | rd_hilo_i | wr_hi_i | wr_lo_i);

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit (WIDTH=32) against an arithmetic reference model.
module tb_mul_div_unit;

  localparam int W = 32;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         reset_i = 1'b1;
  logic         start_i = 1'b0;
  logic [1:0]   op_i2 = 2'b00;
  logic [W-1:0] a_i = '0, b_i = '0, wdata_i = '0;
  logic         flush_i = 1'b0, rd_hilo_i = 1'b0, wr_hi_i = 1'b0, wr_lo_i = 1'b0;
  logic [W-1:0] hi_o, lo_o;
  logic         busy_o, done_o, stall_o;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .op_i2(op_i2),
    .a_i(a_i), .b_i(b_i), .flush_i(flush_i), .rd_hilo_i(rd_hilo_i),
    .wr_hi_i(wr_hi_i), .wr_lo_i(wr_lo_i), .wdata_i(wdata_i),
    .hi_o(hi_o), .lo_o(lo_o), .busy_o(busy_o), .done_o(done_o), .stall_o(stall_o)
  );

  // Reference result as {HI, LO}, from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_model(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0: begin q = sa * sb; return q; end
      2'd1: begin u = {32'b0, a} * {32'b0, b}; return u; end
      2'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // All tasks begin and end 1ns after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    start_i = 1'b1;
    op_i2   = op;
    a_i     = a;
    b_i     = b;
    tick();
    start_i = 1'b0;
    a_i     = $urandom;
    b_i     = $urandom;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 100) begin
      tick();
      cyc++;
      if (done_o === 1'b1) break;
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (2) tick();
    checks++; if (hi_o !== 32'h0) begin failures++; $display("FAIL reset_hi: got %h expected 0", hi_o); end
    checks++; if (lo_o !== 32'h0) begin failures++; $display("FAIL reset_lo: got %h expected 0", lo_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done_o); end
    reset_i = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic [1:0]  ops[8]  = '{2'd0, 2'd3, 2'd2, 2'd1, 2'd2, 2'd3, 2'd2, 2'd2};
    logic [31:0] as[8]   = '{32'hFFFF_FFFD, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFFF,
                             32'h8000_0000, 32'd5, 32'hFFFF_FFF7, 32'd7};
    logic [31:0] bs[8]   = '{32'd7, 32'd7, 32'd2, 32'hFFFF_FFFF,
                             32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFE};
    logic [31:0] ehi[8]  = '{32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
                             32'h0, 32'd5, 32'hFFFF_FFF7, 32'd1};
    logic [31:0] elo[8]  = '{32'hFFFF_FFEB, 32'd14, 32'hFFFF_FFFD, 32'h0000_0001,
                             32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    int cyc;
    for (int i = 0; i < 8; i++) begin
      start_op(ops[i], as[i], bs[i]);
      wait_done(cyc);
      checks++; if (cyc !== LAT) begin failures++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, cyc, LAT); end
      checks++; if (hi_o !== ehi[i]) begin failures++; $display("FAIL dir%0d_hi: got %h expected %h", i, hi_o, ehi[i]); end
      checks++; if (lo_o !== elo[i]) begin failures++; $display("FAIL dir%0d_lo: got %h expected %h", i, lo_o, elo[i]); end
      tick();
      checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL dir%0d_done_pulse: got %b expected 0", i, done_o); end
    end
  endtask

  // rd_hilo held for the whole op, plus a second start mid-op that must be ignored.
  task automatic test_stall_window();
    logic exp_busy, exp_done;
    rd_hilo_i = 1'b1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL stall_idle: got %b expected 0", stall_o); end
    start_op(2'd0, 32'hFFFF_FFFD, 32'd7);
    for (int n = 1; n <= LAT + 1; n++) begin
      exp_busy = (n <= LAT);
      exp_done = (n == LAT + 1);
      checks++; if (busy_o !== exp_busy) begin failures++; $display("FAIL win_busy_c%0d: got %b expected %b", n, busy_o, exp_busy); end
      checks++; if (stall_o !== exp_busy) begin failures++; $display("FAIL win_stall_c%0d: got %b expected %b", n, stall_o, exp_busy); end
      checks++; if (done_o !== exp_done) begin failures++; $display("FAIL win_done_c%0d: got %b expected %b", n, done_o, exp_done); end
      if (n == 5) begin start_i = 1'b1; op_i2 = 2'd3; a_i = 32'd100; b_i = 32'd7; end
      if (n == 9) start_i = 1'b0;
      if (n <= LAT) tick();
    end
    checks++; if (hi_o !== 32'hFFFF_FFFF) begin failures++; $display("FAIL win_hi: got %h expected ffffffff", hi_o); end
    checks++; if (lo_o !== 32'hFFFF_FFEB) begin failures++; $display("FAIL win_lo: got %h expected ffffffeb", lo_o); end
    rd_hilo_i = 1'b0;
    tick();
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL win_no_restart: got %b expected 0", busy_o); end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b, e;
    logic [63:0] r;
    int cyc;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = pick_operand();
      b  = pick_operand();
      r  = ref_model(op, a, b);
      exp_q.push_back(r[63:32]);
      exp_q.push_back(r[31:0]);
      start_op(op, a, b);
      wait_done(cyc);
      checks++; if (cyc !== LAT) begin failures++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, cyc, LAT); end
      e = exp_q.pop_front();
      checks++; if (hi_o !== e) begin failures++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, hi_o, e); end
      e = exp_q.pop_front();
      checks++; if (lo_o !== e) begin failures++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, lo_o, e); end
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  // A new start in the done cycle is accepted immediately.
  task automatic test_back_to_back();
    logic [1:0]  op1, op2;
    logic [31:0] a1, b1, a2, b2, e;
    logic [63:0] r;
    int cyc;
    op1 = 2'($urandom_range(0, 3)); a1 = $urandom; b1 = pick_operand();
    op2 = 2'($urandom_range(0, 3)); a2 = pick_operand(); b2 = $urandom;
    r = ref_model(op1, a1, b1); exp_q.push_back(r[63:32]); exp_q.push_back(r[31:0]);
    r = ref_model(op2, a2, b2); exp_q.push_back(r[63:32]); exp_q.push_back(r[31:0]);
    start_op(op1, a1, b1);
    wait_done(cyc);
    e = exp_q.pop_front();
    checks++; if (hi_o !== e) begin failures++; $display("FAIL b2b_first_hi: got %h expected %h", hi_o, e); end
    e = exp_q.pop_front();
    checks++; if (lo_o !== e) begin failures++; $display("FAIL b2b_first_lo: got %h expected %h", lo_o, e); end
    start_op(op2, a2, b2);
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL b2b_accept: got %b expected 1", busy_o); end
    wait_done(cyc);
    checks++; if (cyc !== LAT) begin failures++; $display("FAIL b2b_latency: got %0d expected %0d", cyc, LAT); end
    e = exp_q.pop_front();
    checks++; if (hi_o !== e) begin failures++; $display("FAIL b2b_second_hi: got %h expected %h", hi_o, e); end
    e = exp_q.pop_front();
    checks++; if (lo_o !== e) begin failures++; $display("FAIL b2b_second_lo: got %h expected %h", lo_o, e); end
    tick();
  endtask

  task automatic test_flush();
    int cyc;
    int done_seen = 0;
    start_op(2'd3, 32'd100, 32'd7);
    wait_done(cyc);
    tick();
    start_op(2'd1, $urandom, $urandom);
    repeat (9) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL flush_busy: got %b expected 0", busy_o); end
    for (int n = 0; n < 40; n++) begin
      if (done_o === 1'b1) done_seen++;
      tick();
    end
    checks++; if (done_seen !== 0) begin failures++; $display("FAIL flush_done: got %0d pulses expected 0", done_seen); end
    checks++; if (hi_o !== 32'd2) begin failures++; $display("FAIL flush_hi: got %h expected 2", hi_o); end
    checks++; if (lo_o !== 32'd14) begin failures++; $display("FAIL flush_lo: got %h expected e", lo_o); end
  endtask

  task automatic test_reset_mid();
    start_op(2'd2, $urandom, 32'd3);
    repeat (5) tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    checks++; if (hi_o !== 32'h0) begin failures++; $display("FAIL rstmid_hi: got %h expected 0", hi_o); end
    checks++; if (lo_o !== 32'h0) begin failures++; $display("FAIL rstmid_lo: got %h expected 0", lo_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b expected 0", busy_o); end
    tick();
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] d, ehi, elo;
    logic [63:0] r;
    int cyc;
    wr_hi_i = 1'b1; wdata_i = 32'h0000_1234;
    tick();
    wr_hi_i = 1'b0;
    checks++; if (hi_o !== 32'h0000_1234) begin failures++; $display("FAIL mthi_hi: got %h expected 00001234", hi_o); end
    checks++; if (lo_o !== 32'h0) begin failures++; $display("FAIL mthi_lo_kept: got %h expected 0", lo_o); end
    d = $urandom;
    wr_hi_i = 1'b1; wr_lo_i = 1'b1; wdata_i = d;
    tick();
    wr_hi_i = 1'b0; wr_lo_i = 1'b0;
    checks++; if (hi_o !== d) begin failures++; $display("FAIL mtboth_hi: got %h expected %h", hi_o, d); end
    checks++; if (lo_o !== d) begin failures++; $display("FAIL mtboth_lo: got %h expected %h", lo_o, d); end
    r = ref_model(2'd0, 32'd12, 32'hFFFF_FFFB);
    ehi = r[63:32]; elo = r[31:0];
    start_op(2'd0, 32'd12, 32'hFFFF_FFFB);
    wr_lo_i = 1'b1; wdata_i = 32'hDEAD_BEEF;
    tick();
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL mtlo_busy_stall: got %b expected 1", stall_o); end
    tick();
    wr_lo_i = 1'b0;
    wait_done(cyc);
    checks++; if (hi_o !== ehi) begin failures++; $display("FAIL mtlo_busy_hi: got %h expected %h", hi_o, ehi); end
    checks++; if (lo_o !== elo) begin failures++; $display("FAIL mtlo_busy_lo: got %h expected %h", lo_o, elo); end
    tick();
  endtask

  task automatic test_start_flush();
    logic [31:0] hi_before, lo_before;
    hi_before = hi_o; lo_before = lo_o;
    start_i = 1'b1; flush_i = 1'b1; op_i2 = 2'd1; a_i = $urandom; b_i = $urandom;
    tick();
    start_i = 1'b0; flush_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL stflush_busy: got %b expected 0", busy_o); end
    repeat (3) tick();
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL stflush_busy_later: got %b expected 0", busy_o); end
    checks++; if (lo_o !== lo_before) begin failures++; $display("FAIL stflush_lo: got %h expected %h", lo_o, lo_before); end
    checks++; if (hi_o !== hi_before) begin failures++; $display("FAIL stflush_hi: got %h expected %h", hi_o, hi_before); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_directed();
    test_stall_window();
    test_random();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_mthi_mtlo();
    test_start_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
